// File: rtl/contador_direccion_if.sv
// Bus interface for the two-sensor direction detector / occupancy counter.
// Groups the sensor inputs, count clear and all detector outputs.
//   master : drives a, b, clr; observes inc, dec, err, count, full, empty
//   slave  : the detector side (inverse directions)
interface contador_direccion_if #(
  parameter int unsigned COUNT_W = 4
);
  logic               a;      // raw sensor A, asynchronous to clk
  logic               b;      // raw sensor B, asynchronous to clk
  logic               clr;    // synchronous clear of count
  logic               inc;    // one-cycle pulse: a-then-b completed
  logic               dec;    // one-cycle pulse: b-then-a completed
  logic               err;    // one-cycle pulse: timeout or simultaneous arrival
  logic [COUNT_W-1:0] count;  // saturating net event count
  logic               full;   // count == MAX_COUNT
  logic               empty;  // count == 0

  modport master (
    output a, b, clr,
    input  inc, dec, err, count, full, empty
  );

  modport slave (
    input  a, b, clr,
    output inc, dec, err, count, full, empty
  );
endinterface

// File: rtl/contador_direccion.sv
// Two-sensor direction detector with saturating occupancy counter.
// Raw sensors are synchronised (2 flops) and debounced; the FSM turns an
// a-then-b sequence into an inc pulse and b-then-a into a dec pulse, aborts
// on retreat, flags timeout / simultaneous arrival with err, and only re-arms
// once both filtered sensors are clear.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : contador_direccion_if slave (a, b, clr in; inc, dec, err,
//           count, full, empty out)
module contador_direccion #(
  parameter int unsigned DEB_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned COUNT_W    = 4,
  parameter int unsigned MAX_COUNT  = 9
) (
  input logic                  clk,
  input logic                  reset,
  contador_direccion_if.slave  bus
);

  // Debounce counter only needs to reach DEB_CYCLES-1 before toggling.
  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  // Timer counts 0..TIMEOUT-1 while waiting for the second sensor.
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TO_LAST = TW'(TO_LAST_I);

  localparam logic [COUNT_W-1:0] MAX_C = COUNT_W'(MAX_COUNT);

  typedef enum logic [2:0] {
    StIdle,
    StAFirst,
    StBFirst,
    StADone,
    StBDone,
    StErr,
    StWaitClear
  } state_t;

  // Channel 0 is sensor A, channel 1 is sensor B.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    filt;
  logic [DW-1:0] deb_cnt [2];

  state_t        state;
  logic [TW-1:0] timer;
  logic          pulse_inc;
  logic          pulse_dec;
  logic          pulse_err;
  logic [COUNT_W-1:0] count;

  logic af;
  logic bf;

  assign raw = {bus.b, bus.a};
  assign af  = filt[0];
  assign bf  = filt[1];

  // Synchroniser and debounce filter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      for (int i = 0; i < 2; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            filt[i]    <= ~filt[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Sequence FSM; pulses are registered together with the state so they are
  // high exactly while the FSM sits in StADone / StBDone / StErr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      timer     <= '0;
      pulse_inc <= 1'b0;
      pulse_dec <= 1'b0;
      pulse_err <= 1'b0;
    end else begin
      pulse_inc <= 1'b0;
      pulse_dec <= 1'b0;
      pulse_err <= 1'b0;
      unique case (state)
        StIdle: begin
          timer <= '0;  // guarantees a fresh timer on entry to the FIRST states
          if (af && !bf) begin
            state <= StAFirst;
          end else if (!af && bf) begin
            state <= StBFirst;
          end else if (af && bf) begin
            state     <= StErr;
            pulse_err <= 1'b1;
          end
        end
        StAFirst: begin
          if (bf) begin
            state     <= StADone;
            pulse_inc <= 1'b1;
          end else if (!af) begin
            state <= StIdle;
          end else if ((TIMEOUT != 0) && (timer == TO_LAST)) begin
            state     <= StErr;
            pulse_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StBFirst: begin
          if (af) begin
            state     <= StBDone;
            pulse_dec <= 1'b1;
          end else if (!bf) begin
            state <= StIdle;
          end else if ((TIMEOUT != 0) && (timer == TO_LAST)) begin
            state     <= StErr;
            pulse_err <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        StADone, StBDone, StErr: begin
          state <= StWaitClear;
        end
        StWaitClear: begin
          if (!af && !bf) begin
            state <= StIdle;
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  // Occupancy counter: clr beats inc beats dec; out-of-range steps dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (bus.clr) begin
      count <= '0;
    end else if (pulse_inc && (count < MAX_C)) begin
      count <= count + COUNT_W'(1);
    end else if (pulse_dec && (count != '0)) begin
      count <= count - COUNT_W'(1);
    end
  end

  assign bus.inc   = pulse_inc;
  assign bus.dec   = pulse_dec;
  assign bus.err   = pulse_err;
  assign bus.count = count;
  assign bus.full  = (count == MAX_C);
  assign bus.empty = (count == '0);

endmodule

// File: tb/tb_contador_direccion.sv
// Self-checking bench for contador_direccion (DEB_CYCLES=2, TIMEOUT=16,
// COUNT_W=4, MAX_COUNT=9): reset state, exact inc latency, a table of
// sensor sequences with hand-derived results, clr/inc priority, reset
// mid-sequence, and random sequences checked against a counting model.
module tb_contador_direccion;

  localparam int MAXC = 9;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  contador_direccion_if #(.COUNT_W(4)) bus ();

  contador_direccion #(
    .DEB_CYCLES (2),
    .TIMEOUT    (16),
    .COUNT_W    (4),
    .MAX_COUNT  (MAXC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {OpFwd, OpRev, OpRetreat, OpGlitch, OpTimeout, OpSimul, OpClr} op_t;

  typedef struct {
    op_t op;
    int  cnt;
    int  d_inc;
    int  d_dec;
    int  d_err;
    int  full;
    int  empty;
  } vec_t;

  vec_t tbl[$];

  int n_tests = 0;
  int n_fail  = 0;

  // Pulse monitor: counts cycles in which each pulse is high.
  int n_inc = 0;
  int n_dec = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (!reset) begin
      if (bus.inc) n_inc <= n_inc + 1;
      if (bus.dec) n_dec <= n_dec + 1;
      if (bus.err) n_err <= n_err + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic run_op(input op_t op);
    case (op)
      OpFwd: begin
        bus.a = 1'b1; cyc(10);
        bus.b = 1'b1; cyc(10);
        bus.a = 1'b0; bus.b = 1'b0; cyc(10);
      end
      OpRev: begin
        bus.b = 1'b1; cyc(10);
        bus.a = 1'b1; cyc(10);
        bus.a = 1'b0; bus.b = 1'b0; cyc(10);
      end
      OpRetreat: begin
        bus.a = 1'b1; cyc(8);
        bus.a = 1'b0; cyc(10);
      end
      OpGlitch: begin
        bus.a = 1'b1; cyc(1);
        bus.a = 1'b0; cyc(8);
      end
      OpTimeout: begin
        // b arrives long after the timeout while a is still held
        bus.a = 1'b1; cyc(30);
        bus.b = 1'b1; cyc(10);
        bus.a = 1'b0; bus.b = 1'b0; cyc(10);
      end
      OpSimul: begin
        bus.a = 1'b1; bus.b = 1'b1; cyc(10);
        bus.a = 1'b0; bus.b = 1'b0; cyc(10);
      end
      default: begin
        bus.clr = 1'b1; cyc(1);
        bus.clr = 1'b0; cyc(2);
      end
    endcase
  endtask

  task automatic add(input op_t op, input int cnt, input int di, input int dd,
                     input int de, input int fl, input int em);
    vec_t v;
    v.op = op; v.cnt = cnt; v.d_inc = di; v.d_dec = dd; v.d_err = de;
    v.full = fl; v.empty = em;
    tbl.push_back(v);
  endtask

  // Apply one op and compare count, flags and pulse counts.
  task automatic apply_check(input string tag, input op_t op, input int cnt, input int di,
                             input int dd, input int de, input int fl, input int em);
    int i0, d0, e0;
    i0 = n_inc; d0 = n_dec; e0 = n_err;
    run_op(op);
    check({tag, " count"}, int'(bus.count), cnt);
    check({tag, " inc pulses"}, n_inc - i0, di);
    check({tag, " dec pulses"}, n_dec - d0, dd);
    check({tag, " err pulses"}, n_err - e0, de);
    check({tag, " full"}, int'(bus.full), fl);
    check({tag, " empty"}, int'(bus.empty), em);
  endtask

  // Forward pass with exact inc timing; optionally clr in the pulse cycle.
  task automatic fwd_timed(input bit clr_at, input int exp_after);
    bus.a = 1'b1; cyc(10);
    bus.b = 1'b1;  // b sampled at the next rising edge (edge k)
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      check($sformatf("latency inc low %0d", i), int'(bus.inc), 0);
    end
    cyc(1);
    check("latency inc high", int'(bus.inc), 1);
    check("latency dec low", int'(bus.dec), 0);
    check("latency err low", int'(bus.err), 0);
    if (clr_at) bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
    check("latency inc one cycle", int'(bus.inc), 0);
    check("latency count after", int'(bus.count), exp_after);
    cyc(4);
    bus.a = 1'b0; bus.b = 1'b0; cyc(10);
  endtask

  op_t pick [10] = '{OpFwd, OpFwd, OpFwd, OpRev, OpRev, OpRetreat, OpGlitch,
                     OpTimeout, OpSimul, OpClr};

  initial begin
    int m_count, e_inc, e_dec, e_err;
    int i0, d0, e0;
    op_t op;

    bus.a = 1'b0; bus.b = 1'b0; bus.clr = 1'b0;
    reset = 1'b1;
    cyc(3);
    check("reset count", int'(bus.count), 0);
    check("reset empty", int'(bus.empty), 1);
    check("reset full", int'(bus.full), 0);
    check("reset pulses", int'({bus.inc, bus.dec, bus.err}), 0);
    reset = 1'b0;
    cyc(3);

    fwd_timed(1'b0, 1);

    // Sequence table; results derived by hand from the sensor rules.
    add(OpGlitch,  1, 0, 0, 0, 0, 0);
    add(OpRev,     0, 0, 1, 0, 0, 1);
    add(OpRetreat, 0, 0, 0, 0, 0, 1);
    add(OpTimeout, 0, 0, 0, 1, 0, 1);
    for (int i = 1; i <= 11; i++) begin
      add(OpFwd, (i < MAXC) ? i : MAXC, 1, 0, 0, (i >= MAXC) ? 1 : 0, 0);
    end
    add(OpClr,     0, 0, 0, 0, 0, 1);
    add(OpRev,     0, 0, 1, 0, 0, 1);
    add(OpSimul,   0, 0, 0, 1, 0, 1);
    add(OpFwd,     1, 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply_check($sformatf("tbl[%0d]", i), tbl[i].op, tbl[i].cnt, tbl[i].d_inc,
                  tbl[i].d_dec, tbl[i].d_err, tbl[i].full, tbl[i].empty);
    end

    // clr wins over a coincident inc.
    fwd_timed(1'b1, 0);

    // Reset in the middle of an a-then-b sequence.
    run_op(OpFwd);
    check("pre-reset count", int'(bus.count), 1);
    bus.a = 1'b1; cyc(6);
    reset = 1'b1; bus.a = 1'b0;
    #1;
    check("midreset count", int'(bus.count), 0);
    check("midreset pulses", int'({bus.inc, bus.dec, bus.err}), 0);
    check("midreset empty", int'(bus.empty), 1);
    cyc(3);
    reset = 1'b0;
    i0 = n_inc; d0 = n_dec;
    bus.b = 1'b1; cyc(10);
    bus.b = 1'b0; cyc(10);
    check("post-reset b alone inc", n_inc - i0, 0);
    check("post-reset b alone dec", n_dec - d0, 0);
    check("post-reset count", int'(bus.count), 0);

    // Random sequences against an event-level counting model.
    m_count = 0;
    for (int t = 0; t < 40; t++) begin
      op = pick[$urandom_range(0, 9)];
      e_inc = 0; e_dec = 0; e_err = 0;
      case (op)
        OpFwd:     begin e_inc = 1; m_count = (m_count < MAXC) ? m_count + 1 : MAXC; end
        OpRev:     begin e_dec = 1; m_count = (m_count > 0) ? m_count - 1 : 0; end
        OpTimeout: e_err = 1;
        OpSimul:   e_err = 1;
        OpClr:     m_count = 0;
        default:   ;
      endcase
      apply_check($sformatf("rnd[%0d] op%0d", t, int'(op)), op, m_count, e_inc, e_dec,
                  e_err, (m_count == MAXC) ? 1 : 0, (m_count == 0) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
